// File: rtl/s_axi_lite_regs.sv
// AXI4-Lite responder exposing REG_NUM 32-bit read/write registers with byte strobes,
// SLVERR on bad addresses, and per-register write pulses for user logic.
module s_axi_lite_regs #(
  parameter int DWIDTH  = 32,
  parameter int REGSIZE = 8,
  parameter int REG_NUM = 16
) (
  input  logic                      clk,
  input  logic                      xrst,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [REGSIZE-1:0]        awaddr,
  input  logic [2:0]                awprot,
  input  logic                      wvalid,
  output logic                      wready,
  input  logic [DWIDTH-1:0]         wdata,
  input  logic [DWIDTH/8-1:0]       wstrb,
  output logic                      bvalid,
  input  logic                      bready,
  output logic [1:0]                bresp,
  input  logic                      arvalid,
  output logic                      arready,
  input  logic [REGSIZE-1:0]        araddr,
  input  logic [2:0]                arprot,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [DWIDTH-1:0]         rdata,
  output logic [1:0]                rresp,
  output logic [REG_NUM*DWIDTH-1:0] reg_flat,
  output logic [REG_NUM-1:0]        wr_pulse
);
  localparam int NB   = DWIDTH / 8;
  localparam int IDXW = REGSIZE - 2;
  localparam int LIDX = $clog2(REG_NUM);

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_e;

  wstate_e                       wstate_q, wstate_d;
  logic [REGSIZE-1:0]            awaddr_q;
  logic [DWIDTH-1:0]             wdata_q;
  logic [NB-1:0]                 wstrb_q;
  logic [1:0]                    bresp_q;
  logic                          rvalid_q;
  logic [DWIDTH-1:0]             rdata_q;
  logic [1:0]                    rresp_q;
  logic [REG_NUM-1:0][DWIDTH-1:0] regs_w;

  logic                          aw_hs, w_hs, ar_hs, commit, c_bad, r_bad;
  logic [REGSIZE-1:0]            c_addr;
  logic [DWIDTH-1:0]             c_data;
  logic [NB-1:0]                 c_strb;
  logic [IDXW-1:0]               c_idx;

  logic unused_prot;
  assign unused_prot = ^{awprot, arprot};

  function automatic logic addr_bad(input logic [REGSIZE-1:0] a);
    return (int'(a[REGSIZE-1:2]) >= REG_NUM) || (a[1:0] != 2'b00);
  endfunction

  always_comb begin
    awready  = (wstate_q == W_IDLE) || (wstate_q == W_HAVE_W);
    wready   = (wstate_q == W_IDLE) || (wstate_q == W_HAVE_AW);
    aw_hs    = awvalid && awready;
    w_hs     = wvalid && wready;
    commit   = ((wstate_q == W_IDLE) && aw_hs && w_hs) ||
               ((wstate_q == W_HAVE_AW) && w_hs) ||
               ((wstate_q == W_HAVE_W) && aw_hs);
    // The channel handshaking now supplies its live value; the other comes from the latch.
    c_addr   = (wstate_q == W_HAVE_AW) ? awaddr_q : awaddr;
    c_data   = (wstate_q == W_HAVE_W) ? wdata_q : wdata;
    c_strb   = (wstate_q == W_HAVE_W) ? wstrb_q : wstrb;
    c_idx    = c_addr[REGSIZE-1:2];
    c_bad    = addr_bad(c_addr);
    wstate_d = wstate_q;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) wstate_d = W_RESP;
        else if (aw_hs)    wstate_d = W_HAVE_AW;
        else if (w_hs)     wstate_d = W_HAVE_W;
      end
      W_HAVE_AW: if (w_hs)   wstate_d = W_RESP;
      W_HAVE_W:  if (aw_hs)  wstate_d = W_RESP;
      W_RESP:    if (bready) wstate_d = W_IDLE;
      default:               wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      wstate_q <= W_IDLE;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= 2'b00;
    end else begin
      wstate_q <= wstate_d;
      if (aw_hs) awaddr_q <= awaddr;
      if (w_hs) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (commit) bresp_q <= c_bad ? 2'b10 : 2'b00;
    end
  end

  genvar gi, gb;
  for (gi = 0; gi < REG_NUM; gi++) begin : g_reg
    logic hit;
    logic pulse_q;
    assign hit = commit && !c_bad && (c_idx == IDXW'(gi));

    always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) pulse_q <= 1'b0;
      else       pulse_q <= hit;
    end
    assign wr_pulse[gi] = pulse_q;

    for (gb = 0; gb < NB; gb++) begin : g_byte
      logic [7:0] byte_q;
      always_ff @(posedge clk or negedge xrst) begin
        if (!xrst)                 byte_q <= 8'h00;
        else if (hit && c_strb[gb]) byte_q <= c_data[8*gb +: 8];
      end
      assign reg_flat[gi*DWIDTH + 8*gb +: 8] = byte_q;
    end
  end

  assign regs_w = reg_flat;

  // Read path samples the registers' current (pre-write) value at the handshake edge.
  always_comb begin
    arready = !rvalid_q;
    ar_hs   = arvalid && arready;
    r_bad   = addr_bad(araddr);
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= r_bad ? '0 : regs_w[araddr[LIDX+1:2]];
      rresp_q  <= r_bad ? 2'b10 : 2'b00;
    end else if (rvalid_q && rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign bvalid = (wstate_q == W_RESP);
  assign bresp  = bresp_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
endmodule

// File: doc/s_axi_lite_regs.md
Name: s_axi_lite_regs

Overview:
AXI4-Lite slave (responder) exposing REG_NUM 32-bit read/write registers to an AXI4-Lite master. It is the target end for the team's AXI-Lite master traffic generator. It accepts single-beat writes and reads, applies byte strobes and reports SLVERR for bad addresses. Register contents and per-register write pulses are exported to user logic.

Parameters:
DWIDTH, 32, data bus width; 32 is the only supported value.
REGSIZE, 8, address width in bits.
REG_NUM, 16, number of registers; must satisfy 4*REG_NUM <= 2**REGSIZE.

Ports:
clk  in  1  clock; all logic on the rising edge.
xrst  in  1  asynchronous active-low reset.
awvalid  in  1  write address valid.
awready  out  1  write address ready.
awaddr  in  REGSIZE  byte address of the write.
awprot  in  3  ignored.
wvalid  in  1  write data valid.
wready  out  1  write data ready.
wdata  in  DWIDTH  write data.
wstrb  in  DWIDTH/8  byte strobes.
bvalid  out  1  write response valid.
bready  in  1  write response ready.
bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
arvalid  in  1  read address valid.
arready  out  1  read address ready.
araddr  in  REGSIZE  byte address of the read.
arprot  in  3  ignored.
rvalid  out  1  read data valid.
rready  in  1  read data ready.
rdata  out  DWIDTH  read data.
rresp  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
reg_flat  out  REG_NUM*DWIDTH  register contents; register i occupies bits [i*DWIDTH +: DWIDTH].
wr_pulse  out  REG_NUM  one-cycle pulse per register on a successful write.

Behaviour:
- Reset (xrst=0, asynchronous): all registers 0; bvalid, rvalid, wr_pulse = 0; bresp, rresp, rdata = 0; AW/W holding flags cleared. awready, wready and arready are 1 the first cycle after reset.
- Address decode:
  - idx = addr[REGSIZE-1:2].
  - Error if idx >= REG_NUM or addr[1:0] != 0.
- Write channel, FSM states W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP:
  - awready = 1 in W_IDLE and W_HAVE_W; wready = 1 in W_IDLE and W_HAVE_AW; both 0 in W_RESP.
  - AW handshake alone: latch awaddr, go to W_HAVE_AW. W handshake alone: latch wdata/wstrb, go to W_HAVE_W.
  - Commit happens on the edge where the second handshake completes, or where both complete in the same cycle from W_IDLE. The commit uses the incoming value for the channel handshaking that cycle and the latched value for the other.
  - Commit, good address: for each byte b with wstrb[b]=1, reg[idx][8b+:8] <= data byte. wr_pulse[idx]=1 for exactly the next cycle; wr_pulse[idx] is set even when wstrb=0.
  - Commit, bad address: no register change, no wr_pulse.
  - In the cycle after commit: bvalid=1, bresp per decode, state W_RESP.
  - bvalid, bresp held stable until bready=1. On that edge bvalid drops and the state returns to W_IDLE. Earliest next AW accept is the following cycle.
  - Write latency from handshake edge to bvalid rise: 1 cycle.
- Read channel:
  - arready = !rvalid.
  - On AR handshake, the next cycle has rvalid=1, rdata = reg[idx] sampled at the handshake edge, rresp per decode. On error, rdata = 0 and rresp = 2'b10.
  - rvalid, rdata, rresp held stable until rready=1; rvalid drops on that edge.
  - No back-to-back reads: at most one read every 2 cycles when rready is tied high.
- Simultaneous read/write to the same register on one edge: the read returns the pre-write value.
- Read and write channels are fully independent.
- awprot and arprot have no effect.
- Reset asserted mid-transaction aborts it: pending responses are dropped and latched AW/W are discarded.

Test Plan:
1. AW+W same cycle: awaddr=0x04, wdata=0xDEADBEEF, wstrb=4'hF, bready=1 -> bvalid high next cycle, bresp=00, wr_pulse[1] for 1 cycle, reg_flat[63:32]=0xDEADBEEF. Then read 0x04 -> rdata=0xDEADBEEF, rresp=00.
2. AW 3 cycles before W, then W before AW, at addresses 0x08 and 0x0C -> awready drops while waiting for W, wready drops while waiting for AW. Each write commits on the second handshake and returns bresp=00.
3. Partial strobes: reg2=0x11223344, write 0xAABBCCDD with wstrb=4'b0101 -> reg2=0x11BB33DD.
4. Bad addresses: awaddr=0x40 (REG_NUM=16), then awaddr=0x06 -> bresp=10, no reg_flat change, no wr_pulse. Read 0x40 -> rresp=10, rdata=0.
5. Backpressure: hold rready=0 for 5 cycles after a read, and bready=0 after a write -> rvalid/rdata and bvalid/bresp stay stable, arready and awready/wready stay 0; release -> accept next transfer the cycle after.
6. Master sweep: 4 writes at 0x00/0x04/0x08/0x0C with data 0,1,3,6 -> all OKAY, then readback matches. Pull xrst low mid-write (AW latched, W pending) -> all outputs return to reset values immediately and the registers read 0.
